left_shift_unit: RTL and testbench

Sequential 16-bit left shifter, the counterpart of the combinational sign-preserving right shifter in the arithmetic datapath. It accepts an operand and a 4-bit shift range on a start pulse and shifts left one bit per clock, filling zeros into bit 0. It returns the result with a one-cycle done pulse and an optional arithmetic-overflow flag. It sits beside the right shifter and serves the same operand/range producers.

---
 rtl/left_shift_unit_if.sv | 22 ++
 rtl/left_shift_unit.sv | 141 ++++++++++++++
 tb/tb_left_shift_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/left_shift_unit_if.sv
// Operand/result bus for left_shift_unit.
// The producer drives start/number/range through the master modport; the
// shifter returns shifted/busy/done/overflow through the slave modport.
interface left_shift_unit_if;
    logic        start;
    logic [15:0] number;
    logic [3:0]  range;
    logic [15:0] shifted;
    logic        busy;
    logic        done;
    logic        overflow;

    modport master (
        output start, number, range,
        input  shifted, busy, done, overflow
    );

    modport slave (
        input  start, number, range,
        output shifted, busy, done, overflow
    );
endinterface

// File: rtl/left_shift_unit.sv
// Sequential 16-bit left shifter: one bit per clock, zero fill into bit 0.
// The result comes back with a one-cycle done pulse.
// Optional feature macro: LEFT_SHIFT_OVERFLOW_EN. When it is defined, overflow
// reports any sign-bit change seen while shifting. When it is undefined, the
// accumulator is removed and overflow is tied to 0.
module left_shift_unit (
    input  logic               clk,
    input  logic               rst,
    left_shift_unit_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef LEFT_SHIFT_OVERFLOW_EN
    localparam int WORK_MSB = 15;
`else
    // The top work bit only feeds the sign-change detector, so it is dropped
    // when that detector is not built.
    localparam int WORK_MSB = 14;
`endif

    state_t              state_reg, state_next;
    logic [WORK_MSB:0]   work_reg, work_next;
    logic [3:0]          count_reg, count_next;
    logic [15:0]         shifted_reg, shifted_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
`ifdef LEFT_SHIFT_OVERFLOW_EN
    logic                acc_reg, acc_next;
    logic                overflow_reg, overflow_next;
    logic                sign_change;
`endif

    // Work register moved up by one place with a zero entering bit 0.
    logic [15:0] shl;
    assign shl[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_shl
            assign shl[gi] = work_reg[gi-1];
        end
    endgenerate

`ifdef LEFT_SHIFT_OVERFLOW_EN
    // The sign bit changes on this shift when the top two bits differ.
    assign sign_change = work_reg[15] ^ work_reg[14];
`endif

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            work_reg     <= '0;
            count_reg    <= '0;
            shifted_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef LEFT_SHIFT_OVERFLOW_EN
            acc_reg      <= 1'b0;
            overflow_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            work_reg     <= work_next;
            count_reg    <= count_next;
            shifted_reg  <= shifted_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
`ifdef LEFT_SHIFT_OVERFLOW_EN
            acc_reg      <= acc_next;
            overflow_reg <= overflow_next;
`endif
        end
    end

    // Next-state logic: accept in IDLE, shift once per clock in SHIFT.
    always_comb begin
        state_next    = state_reg;
        work_next     = work_reg;
        count_next    = count_reg;
        shifted_next  = shifted_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
`ifdef LEFT_SHIFT_OVERFLOW_EN
        acc_next      = acc_reg;
        overflow_next = overflow_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.range != 4'd0) begin
                        work_next  = bus.number[WORK_MSB:0];
                        count_next = bus.range;
                        busy_next  = 1'b1;
                        state_next = SHIFT;
`ifdef LEFT_SHIFT_OVERFLOW_EN
                        acc_next   = 1'b0;
`endif
                    end else begin
                        // A zero shift completes at once without leaving IDLE.
                        shifted_next  = bus.number;
                        done_next     = 1'b1;
`ifdef LEFT_SHIFT_OVERFLOW_EN
                        overflow_next = 1'b0;
`endif
                    end
                end
            end
            SHIFT: begin
                work_next  = shl[WORK_MSB:0];
                count_next = count_reg - 4'd1;
`ifdef LEFT_SHIFT_OVERFLOW_EN
                acc_next   = acc_reg | sign_change;
`endif
                if (count_reg == 4'd1) begin
                    shifted_next  = shl;
                    done_next     = 1'b1;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
`ifdef LEFT_SHIFT_OVERFLOW_EN
                    overflow_next = acc_reg | sign_change;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.shifted = shifted_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
`ifdef LEFT_SHIFT_OVERFLOW_EN
    assign bus.overflow = overflow_reg;
`else
    assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_left_shift_unit.sv
// Testbench for left_shift_unit: directed cases plus randomized operations.
// Every result is compared with an arithmetic reference model.
module tb_left_shift_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    left_shift_unit_if bus_if ();

    left_shift_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: treat the operand as a signed integer and multiply it by 2**range.
    // The result is the low 16 bits. Overflow means the product no longer fits in 16-bit signed.
    function automatic void model(input logic [15:0] num, input logic [3:0] rng,
                                  output logic [15:0] sh, output logic ov);
        longint v;
        v  = longint'($signed(num)) * (longint'(1) << rng);
        sh = 16'(v);
        ov = (v > 64'sd32767) || (v < -64'sd32768);
`ifndef LEFT_SHIFT_OVERFLOW_EN
        ov = 1'b0;
`endif
    endfunction

    // Issue one request at the current negedge and follow it to completion.
    // The task returns at the negedge where done is seen.
    // With poke set, a junk Start is issued on every busy cycle.
    task automatic run_op(input logic [15:0] num, input logic [3:0] rng, input bit poke,
                          input string tag);
        int          n;
        logic [15:0] prev_sh;
        logic        prev_ov;
        logic [15:0] exp_sh;
        logic        exp_ov;
        prev_sh = bus_if.shifted;
        prev_ov = bus_if.overflow;
        model(num, rng, exp_sh, exp_ov);
        bus_if.start  = 1'b1;
        bus_if.number = num;
        bus_if.range  = rng;
        @(posedge clk);
        #1;
        bus_if.start  = 1'b0;
        bus_if.number = 16'($urandom);
        bus_if.range  = 4'($urandom);
        @(negedge clk);
        n = 0;
        while (bus_if.done !== 1'b1 && n < 40) begin
            check({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
            check({tag, "_hold_shifted"}, 32'(bus_if.shifted), 32'(prev_sh));
            check({tag, "_hold_overflow"}, 32'(bus_if.overflow), 32'(prev_ov));
            if (poke) begin
                bus_if.start  = 1'b1;
                bus_if.number = 16'hFFFF;
                bus_if.range  = 4'd2;
            end
            @(posedge clk);
            #1;
            bus_if.start = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(rng));
        check({tag, "_done"}, 32'(bus_if.done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_shifted"}, 32'(bus_if.shifted), 32'(exp_sh));
        check({tag, "_overflow"}, 32'(bus_if.overflow), 32'(exp_ov));
        $display("op %s number=%h range=%0d shifted=%h overflow=%0b edges=%0d",
                 tag, num, rng, bus_if.shifted, bus_if.overflow, n);
    endtask

    // Idle for a number of cycles.
    // Checks that done stays low and the results do not move.
    task automatic idle_check(input int cycles, input string tag);
        logic [15:0] sh;
        logic        ov;
        sh = bus_if.shifted;
        ov = bus_if.overflow;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_done_low"}, 32'(bus_if.done), 32'd0);
            check({tag, "_busy_low"}, 32'(bus_if.busy), 32'd0);
            check({tag, "_shifted_kept"}, 32'(bus_if.shifted), 32'(sh));
            check({tag, "_overflow_kept"}, 32'(bus_if.overflow), 32'(ov));
        end
    endtask

    initial begin
        logic [15:0] rnum;
        logic [3:0]  rrng;
        logic        rov;
        checks = 0;
        errors = 0;
        rst           = 1'b1;
        bus_if.start  = 1'b0;
        bus_if.number = 16'h0000;
        bus_if.range  = 4'd0;
        #1;
        check("reset_shifted", 32'(bus_if.shifted), 32'h0);
        check("reset_busy", 32'(bus_if.busy), 32'h0);
        check("reset_done", 32'(bus_if.done), 32'h0);
        check("reset_overflow", 32'(bus_if.overflow), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(16'h0003, 4'd4, 1'b0, "shl4");
        idle_check(2, "after_shl4");
        run_op(16'hA5A5, 4'd0, 1'b0, "zero_range");
        idle_check(1, "after_zero");
        run_op(16'h4000, 4'd1, 1'b0, "sign_flip");
        idle_check(1, "after_flip");
        run_op(16'h0001, 4'd15, 1'b0, "max_range");
        idle_check(1, "after_max");
        run_op(16'h0001, 4'd8, 1'b1, "start_ignored");
        idle_check(4, "no_second_done");

        // Back-to-back requests, including a zero-range one in a done cycle.
        run_op(16'h1234, 4'd3, 1'b0, "b2b_a");
        run_op(16'h00F0, 4'd0, 1'b0, "b2b_b");
        run_op(16'h7FFF, 4'd2, 1'b0, "b2b_c");
        idle_check(1, "after_b2b");

        // Reset three edges into an operation.
        bus_if.start  = 1'b1;
        bus_if.number = 16'h00FF;
        bus_if.range  = 4'd8;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_shifted", 32'(bus_if.shifted), 32'h0);
        check("abort_busy", 32'(bus_if.busy), 32'h0);
        check("abort_done", 32'(bus_if.done), 32'h0);
        check("abort_overflow", 32'(bus_if.overflow), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_check(12, "after_abort");
        run_op(16'h0002, 4'd1, 1'b0, "post_reset");
        idle_check(1, "after_post_reset");

        // Randomized operations with random gaps and busy-time interference.
        for (int k = 0; k < 40; k++) begin
            rnum = 16'($urandom);
            rrng = 4'($urandom);
            rov  = 1'($urandom);
            run_op(rnum, rrng, rov, $sformatf("rand%0d", k));
            if (($urandom % 3) == 0)
                idle_check(int'($urandom_range(1, 3)), $sformatf("rand_gap%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
